// File: rtl/speed_tick_gen.sv
// Rate generator: free-running F0/F1/F2 square waves and ticks, plus a glitch-free speed-selected pair.
// Optional macro SPEED_TICK_STEP_EN adds a synchronised step pushbutton that fires single ticks in HALT.
module speed_tick_gen #(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned F0_HZ  = 2,
    parameter int unsigned F1_HZ  = 5,
    parameter int unsigned F2_HZ  = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] SPEED,
`ifdef SPEED_TICK_STEP_EN
    input  logic       step,
`endif
    output logic       sq0,
    output logic       sq1,
    output logic       sq2,
    output logic       tick0,
    output logic       tick1,
    output logic       tick2,
    output logic       sq_sel,
    output logic       tick_sel,
    output logic [1:0] speed_cur,
    output logic       busy
);

    localparam int unsigned HALF0 = (F0_HZ == 32'd0) ? 32'd0 : CLK_HZ / (32'd2 * F0_HZ);
    localparam int unsigned HALF1 = (F1_HZ == 32'd0) ? 32'd0 : CLK_HZ / (32'd2 * F1_HZ);
    localparam int unsigned HALF2 = (F2_HZ == 32'd0) ? 32'd0 : CLK_HZ / (32'd2 * F2_HZ);
    localparam int unsigned HMAX01 = (HALF0 > HALF1) ? HALF0 : HALF1;
    localparam int unsigned HMAX   = (HMAX01 > HALF2) ? HMAX01 : HALF2;
    localparam int          CW     = (HMAX > 32'd1) ? $clog2(HMAX) : 1;

    if ((HALF0 < 32'd1) || (HALF0 * 32'd2 * F0_HZ != CLK_HZ)) begin : g_bad_half0
        $error("speed_tick_gen: CLK_HZ/(2*F0_HZ) must be an integer >= 1");
    end
    if ((HALF1 < 32'd1) || (HALF1 * 32'd2 * F1_HZ != CLK_HZ)) begin : g_bad_half1
        $error("speed_tick_gen: CLK_HZ/(2*F1_HZ) must be an integer >= 1");
    end
    if ((HALF2 < 32'd1) || (HALF2 * 32'd2 * F2_HZ != CLK_HZ)) begin : g_bad_half2
        $error("speed_tick_gen: CLK_HZ/(2*F2_HZ) must be an integer >= 1");
    end

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PEND = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    function automatic logic [CW-1:0] half_m1(input logic [1:0] n);
        case (n)
            2'd0:    half_m1 = CW'(HALF0 - 32'd1);
            2'd1:    half_m1 = CW'(HALF1 - 32'd1);
            2'd2:    half_m1 = CW'(HALF2 - 32'd1);
            default: half_m1 = {CW{1'b0}};
        endcase
    endfunction

    // Index 3 (HALT) deliberately selects a constant low.
    function automatic logic sel_bit(input logic [2:0] vec, input logic [1:0] idx);
        case (idx)
            2'd0:    sel_bit = vec[0];
            2'd1:    sel_bit = vec[1];
            2'd2:    sel_bit = vec[2];
            default: sel_bit = 1'b0;
        endcase
    endfunction

    logic [CW-1:0] cnt_r     [3];
    logic [CW-1:0] cnt_nxt_s [3];
    logic [2:0]    sq_r, sq_nxt_s, tick_r, tick_nxt_s;
    logic [1:0]    spd_m_r, spd_s_r;
    state_t        state_r, state_nxt_s;
    logic [1:0]    speed_cur_r, speed_nxt_s;
    logic          busy_r, busy_nxt_s;
    logic          sq_sel_r, tick_sel_r, sq_sel_nxt_s, tick_sel_nxt_s;
    logic          cur_lo_s, tgt_lo_s, step_tick_s;

    // Next values of the three rate counters, square waves and ticks.
    always_comb begin
        for (int n = 0; n < 3; n++) begin
            if (cnt_r[n] == half_m1(2'(n))) begin
                cnt_nxt_s[n]  = {CW{1'b0}};
                sq_nxt_s[n]   = ~sq_r[n];
                tick_nxt_s[n] = ~sq_r[n];
            end else begin
                cnt_nxt_s[n]  = cnt_r[n] + CW'(32'd1);
                sq_nxt_s[n]   = sq_r[n];
                tick_nxt_s[n] = 1'b0;
            end
        end
    end

    // Rate counter, square wave and tick registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 3; n++) begin
                cnt_r[n] <= {CW{1'b0}};
            end
            sq_r   <= 3'b000;
            tick_r <= 3'b000;
        end else begin
            for (int n = 0; n < 3; n++) begin
                cnt_r[n] <= cnt_nxt_s[n];
            end
            sq_r   <= sq_nxt_s;
            tick_r <= tick_nxt_s;
        end
    end

    // Two-flop synchroniser for the switch-driven speed request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spd_m_r <= 2'd0;
            spd_s_r <= 2'd0;
        end else begin
            spd_m_r <= SPEED;
            spd_s_r <= spd_m_r;
        end
    end

`ifdef SPEED_TICK_STEP_EN
    logic step_m_r, step_s_r, step_d_r, step_pls_r;

    // Step pushbutton synchroniser and rising-edge pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_m_r   <= 1'b0;
            step_s_r   <= 1'b0;
            step_d_r   <= 1'b0;
            step_pls_r <= 1'b0;
        end else begin
            step_m_r   <= step;
            step_s_r   <= step_m_r;
            step_d_r   <= step_s_r;
            step_pls_r <= step_s_r & ~step_d_r;
        end
    end

    assign step_tick_s = step_pls_r & (state_r == ST_HALT) & (state_nxt_s == ST_HALT);
`else
    assign step_tick_s = 1'b0;
`endif

    // Switch only while both the outgoing and incoming waves are low.
    always_comb begin
        state_nxt_s = state_r;
        speed_nxt_s = speed_cur_r;
        busy_nxt_s  = busy_r;
        cur_lo_s    = ~sel_bit(sq_r, speed_cur_r);
        tgt_lo_s    = ~sel_bit(sq_r, spd_s_r);
        case (state_r)
            ST_RUN, ST_HALT: begin
                if (spd_s_r != speed_cur_r) begin
                    state_nxt_s = ST_PEND;
                    busy_nxt_s  = 1'b1;
                end else begin
                    busy_nxt_s  = 1'b0;
                end
            end
            ST_PEND: begin
                if (spd_s_r == speed_cur_r) begin
                    state_nxt_s = (speed_cur_r == 2'd3) ? ST_HALT : ST_RUN;
                    busy_nxt_s  = 1'b0;
                end else if (cur_lo_s && tgt_lo_s) begin
                    speed_nxt_s = spd_s_r;
                    state_nxt_s = (spd_s_r == 2'd3) ? ST_HALT : ST_RUN;
                    busy_nxt_s  = 1'b0;
                end else begin
                    busy_nxt_s  = 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
                speed_nxt_s = 2'd0;
                busy_nxt_s  = 1'b0;
            end
        endcase
        sq_sel_nxt_s   = sel_bit(sq_nxt_s, speed_nxt_s);
        tick_sel_nxt_s = sel_bit(tick_nxt_s, speed_nxt_s) | step_tick_s;
    end

    // Selection state and registered output mux, aligned with the rate registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_RUN;
            speed_cur_r <= 2'd0;
            busy_r      <= 1'b0;
            sq_sel_r    <= 1'b0;
            tick_sel_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            speed_cur_r <= speed_nxt_s;
            busy_r      <= busy_nxt_s;
            sq_sel_r    <= sq_sel_nxt_s;
            tick_sel_r  <= tick_sel_nxt_s;
        end
    end

    assign sq0       = sq_r[0];
    assign sq1       = sq_r[1];
    assign sq2       = sq_r[2];
    assign tick0     = tick_r[0];
    assign tick1     = tick_r[1];
    assign tick2     = tick_r[2];
    assign sq_sel    = sq_sel_r;
    assign tick_sel  = tick_sel_r;
    assign speed_cur = speed_cur_r;
    assign busy      = busy_r;

endmodule
